muldiv_unit: RTL

Iterative multiply/divide unit sitting beside the ALU in the execute stage. It consumes the same register-file operands (a, b) and produces the HI/LO pair read back by mfhi/mflo through the execute result mux. Unlike the ALU's single-cycle `a*b` path, it performs full 64-bit signed and unsigned products and 32-bit signed and unsigned quotient/remainder over 32 cycles. The control unit stalls the pipeline on `busy`.

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply (64-bit product) and 32/32 divide (quotient + remainder) feeding HI/LO.
// Latency: exactly 32 cycles from the accepting edge to HI/LO valid, for every op and operand value.
// Backpressure: busy=1 for the whole run; start is only accepted while idle, with no queueing.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        finish;

  // Operation context captured at the accepting edge
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;       // negate product (mult) or quotient (div)
  logic        neg_r;       // negate remainder: dividend was negative
  logic        dz;          // current division has a zero divisor
  logic [31:0] opb;         // |b|: multiplicand for mult, divisor for div
  logic [63:0] acc;         // product accumulator, or remainder:quotient

  // Operand magnitudes: only the signed ops (op[0]=0) strip the sign
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // One-iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_nx;
  logic [63:0] acc_nx;

  // Sign-corrected result, built from the final iteration's output
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Next-state decode: accept a start when idle, leave RUN after iteration 31
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == 5'd31) begin
          finish   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand magnitudes and sign flags for the incoming request
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (32'd0 - a) : a;
    b_mag     = b_neg ? (32'd0 - b) : b;
  end

  // One shift-add (mult) or restoring shift-subtract (div) step
  always_comb begin
    // Multiply: multiplier sits in the low half and is consumed LSB first
    mul_sum = {1'b0, acc[63:32]} + {1'b0, opb};
    mul_nx  = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
    // Divide: the 33-bit shifted remainder is compared against the divisor;
    // the difference always fits in 32 bits when the subtract is taken
    div_ge  = (acc[63:31] >= {1'b0, opb});
    div_sub = acc[62:31] - opb;
    div_nx  = div_ge ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    acc_nx  = is_div ? div_nx : mul_nx;
  end

  // Sign correction and HI/LO mapping of the completed result
  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_nx) : acc_nx;
    // A zero divisor yields an all-ones quotient regardless of sign; the
    // remainder is then |a| re-signed, which reproduces the original a
    quo_fix  = dz ? 32'hFFFF_FFFF
                  : (neg_q ? (32'd0 - acc_nx[31:0]) : acc_nx[31:0]);
    rem_fix  = neg_r ? (32'd0 - acc_nx[63:32]) : acc_nx[63:32];
    res_hi   = is_div ? rem_fix : prod_fix[63:32];
    res_lo   = is_div ? quo_fix : prod_fix[31:0];
  end

  // Datapath registers, HI/LO and the registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      opb      <= 32'd0;
      acc      <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy <= (state_nx == S_RUN);
      done <= finish;
      if (accept) begin
        cnt      <= 5'd0;
        is_div   <= op[1];
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        dz       <= op[1] & (b == 32'd0);
        opb      <= b_mag;
        acc      <= {32'd0, a_mag};
        div_zero <= 1'b0;
      end else if (state == S_RUN) begin
        cnt <= cnt + 5'd1;
        acc <= acc_nx;
        if (finish) begin
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= dz;
        end
      end else begin
        // Idle with no start: register moves from a
        if (mthi) begin
          hi <= a;
        end
        if (mtlo) begin
          lo <= a;
        end
      end
    end
  end

endmodule
